// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, parity-mode codes and word-length limits.
// Used by the transmitter and intended for a matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [3:0] MIN_WORD_LEN = 4'd5;

    function automatic logic [3:0] clamp_word_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len < MIN_WORD_LEN) return MIN_WORD_LEN;
        if (len > max_len)      return max_len;
        return len;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..OVERSAMPLING-1 and flags the last cycle of each bit.
// Held at zero while clear_in is high so a bit always starts on a full period.
module uart_baud_cnt #(
    parameter int OVERSAMPLING = 16
) (
    input  logic clk_in,
    input  logic nrst_in,
    input  logic clear_in,
    output logic bit_end_out
);

    localparam int CW = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
    localparam logic [CW-1:0] LAST = CW'(OVERSAMPLING - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign bit_end_out = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_in || bit_end_out) cnt_d = '0;
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..DATA_BITS data bits, optional even/odd parity,
// one or two stop bits; frame configuration is latched when the word is accepted.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_in,
    input  logic                 nrst_in,
    input  logic                 data_valid_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    input  logic [3:0]           word_len_in,
    input  logic [1:0]           parity_mode_in,
    input  logic                 stop2_in,
    output logic                 tx_ready_out,
    output logic                 tx_serial_out,
    output logic                 tx_busy_out,
    output logic                 tx_done_out,
    output uart_state_e          state_dbg_out
);

    localparam logic [3:0] MAX_LEN = 4'(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [3:0]           len_q, len_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;

    logic                 bit_end;
    logic                 accept;
    logic                 last_data;
    logic                 last_stop;
    logic [3:0]           len_cap;
    logic [DATA_BITS-1:0] data_masked;

    uart_baud_cnt #(.OVERSAMPLING(OVERSAMPLING)) u_baud (
        .clk_in      (clk_in),
        .nrst_in     (nrst_in),
        .clear_in    (state_q == ST_IDLE),
        .bit_end_out (bit_end)
    );

    assign accept    = (state_q == ST_IDLE) && data_valid_in;
    assign last_data = (bit_idx_q == len_q - 4'd1);
    assign last_stop = (stop_idx_q == stop2_q);

    // Parity is computed once at capture, only over the bits that will be sent.
    always_comb begin
        len_cap = clamp_word_len(word_len_in, MAX_LEN);
        for (int i = 0; i < DATA_BITS; i++) begin
            data_masked[i] = tx_data_in[i] & (i < int'(len_cap));
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (data_valid_in) state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && last_data) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_ready_out  = (state_q == ST_IDLE);
        tx_busy_out   = !tx_ready_out;
        tx_done_out   = (state_q == ST_STOP) && bit_end && last_stop;
        state_dbg_out = state_q;
        case (state_q)
            ST_START:  tx_serial_out = 1'b0;
            ST_DATA:   tx_serial_out = data_q[0];
            ST_PARITY: tx_serial_out = par_bit_q;
            default:   tx_serial_out = 1'b1;
        endcase
    end

    // Frame datapath: data shifts out LSB first; stop_idx marks the second stop bit.
    always_comb begin
        data_d     = data_q;
        len_d      = len_q;
        bit_idx_d  = bit_idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        if (accept) begin
            data_d     = tx_data_in;
            len_d      = len_cap;
            bit_idx_d  = '0;
            par_en_d   = (parity_mode_in == PAR_EVEN) || (parity_mode_in == PAR_ODD);
            par_bit_d  = (^data_masked) ^ (parity_mode_in == PAR_ODD);
            stop2_d    = stop2_in;
            stop_idx_d = 1'b0;
        end else if (bit_end) begin
            if (state_q == ST_DATA) begin
                data_d    = data_q >> 1;
                bit_idx_d = bit_idx_q + 4'd1;
            end
            if (state_q == ST_STOP) stop_idx_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            data_q     <= '0;
            len_q      <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            len_q      <= len_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: per-cycle comparison of the serial line and status outputs
// against a frame model built from the framing rules.
module tb_uart_tx_cfg;
    import uart_pkg::*;

    localparam int OS = 4;
    localparam int DB = 9;

    logic          clk_in = 1'b0;
    logic          nrst_in = 1'b0;
    logic          data_valid_in = 1'b0;
    logic [DB-1:0] tx_data_in = '0;
    logic [3:0]    word_len_in = 4'd8;
    logic [1:0]    parity_mode_in = 2'b00;
    logic          stop2_in = 1'b0;
    logic          tx_ready_out, tx_serial_out, tx_busy_out, tx_done_out;
    uart_state_e   state_dbg_out;

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] exp_q[$];

    uart_tx_cfg #(.OVERSAMPLING(OS), .DATA_BITS(DB)) dut (
        .clk_in         (clk_in),
        .nrst_in        (nrst_in),
        .data_valid_in  (data_valid_in),
        .tx_data_in     (tx_data_in),
        .word_len_in    (word_len_in),
        .parity_mode_in (parity_mode_in),
        .stop2_in       (stop2_in),
        .tx_ready_out   (tx_ready_out),
        .tx_serial_out  (tx_serial_out),
        .tx_busy_out    (tx_busy_out),
        .tx_done_out    (tx_done_out),
        .state_dbg_out  (state_dbg_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_bit(input logic b);
        repeat (OS) exp_q.push_back(b);
    endtask

    // Expected line level for every cycle of one frame.
    task automatic model_frame(input logic [DB-1:0] data, input int len, input int pm, input bit s2);
        int eff;
        logic par;
        eff = (len < 5) ? 5 : ((len > DB) ? DB : len);
        par = 1'b0;
        exp_q.delete();
        push_bit(1'b0);
        for (int i = 0; i < eff; i++) begin
            push_bit(data[i]);
            par = par ^ data[i];
        end
        if (pm == 1) push_bit(par);
        if (pm == 2) push_bit(~par);
        push_bit(1'b1);
        if (s2) push_bit(1'b1);
    endtask

    task automatic offer(input logic [DB-1:0] data, input int len, input int pm, input bit s2);
        tx_data_in     = data;
        word_len_in    = 4'(len);
        parity_mode_in = 2'(pm);
        stop2_in       = s2;
        data_valid_in  = 1'b1;
        model_frame(data, len, pm, s2);
    endtask

    task automatic check_frame(input string tag, input bit hold, input logic [DB-1:0] hold_data,
                               input bit scramble);
        int n;
        logic [0:0] e;
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            @(negedge clk_in);
            e = exp_q.pop_front();
            chk({tag, "/serial"}, 32'(tx_serial_out), 32'(e));
            chk({tag, "/busy"}, 32'(tx_busy_out), 32'd1);
            chk({tag, "/ready"}, 32'(tx_ready_out), 32'd0);
            chk({tag, "/done"}, 32'(tx_done_out), 32'(k == n - 1));
            if (k == 0) begin
                if (hold) begin
                    tx_data_in = hold_data;
                end else if (scramble) begin
                    data_valid_in  = 1'($urandom_range(0, 1));
                    tx_data_in     = DB'($urandom_range(0, (1 << DB) - 1));
                    word_len_in    = 4'($urandom_range(0, 15));
                    parity_mode_in = 2'($urandom_range(0, 3));
                    stop2_in       = 1'($urandom_range(0, 1));
                end else begin
                    data_valid_in = 1'b0;
                end
            end
            if (!hold && k == n - 1) data_valid_in = 1'b0;
        end
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk_in);
        chk({tag, "/idle_serial"}, 32'(tx_serial_out), 32'd1);
        chk({tag, "/idle_ready"}, 32'(tx_ready_out), 32'd1);
        chk({tag, "/idle_busy"}, 32'(tx_busy_out), 32'd0);
        chk({tag, "/idle_done"}, 32'(tx_done_out), 32'd0);
    endtask

    initial begin
        logic [DB-1:0] rd;
        int rl, rp;
        bit rs;

        #2;
        chk("rst/serial", 32'(tx_serial_out), 32'd1);
        chk("rst/ready", 32'(tx_ready_out), 32'd1);
        chk("rst/busy", 32'(tx_busy_out), 32'd0);
        chk("rst/done", 32'(tx_done_out), 32'd0);
        chk("rst/state", 32'(state_dbg_out), 32'(ST_IDLE));

        // First acceptance on the first edge after reset release.
        @(negedge clk_in);
        nrst_in = 1'b1;
        offer(9'h0A5, 8, 0, 1'b0);
        check_frame("a5_none", 1'b0, '0, 1'b0);

        idle_check("a5_none");
        offer(9'h0A5, 8, 1, 1'b0);
        check_frame("a5_even", 1'b0, '0, 1'b0);

        idle_check("a5_even");
        offer(9'h0A5, 8, 2, 1'b0);
        check_frame("a5_odd", 1'b0, '0, 1'b0);

        idle_check("a5_odd");
        offer(9'h1F3, 5, 0, 1'b1);
        check_frame("1f3_len5_stop2", 1'b0, '0, 1'b0);

        idle_check("1f3_len5_stop2");
        offer(9'h1B6, 3, 1, 1'b0);
        check_frame("len3", 1'b0, '0, 1'b0);

        idle_check("len3");
        offer(9'h1B6, 15, 2, 1'b1);
        check_frame("len15", 1'b0, '0, 1'b0);

        // Back-to-back: valid held high, word changed mid-frame.
        idle_check("len15");
        offer(9'h055, 8, 0, 1'b0);
        check_frame("b2b_55", 1'b1, 9'h0AA, 1'b0);
        idle_check("b2b_gap");
        model_frame(9'h0AA, 8, 0, 1'b0);
        check_frame("b2b_aa", 1'b0, '0, 1'b0);

        // Reset in cycle 13 of a frame (data bit 2 of 0xA1, a low bit).
        idle_check("b2b_aa");
        offer(9'h0A1, 8, 0, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk_in);
            if (k == 1) data_valid_in = 1'b0;
        end
        chk("abort/pre_serial", 32'(tx_serial_out), 32'd0);
        #2;
        nrst_in = 1'b0;
        #1;
        chk("abort/serial", 32'(tx_serial_out), 32'd1);
        chk("abort/ready", 32'(tx_ready_out), 32'd1);
        chk("abort/busy", 32'(tx_busy_out), 32'd0);
        chk("abort/done", 32'(tx_done_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            chk("abort/hold_serial", 32'(tx_serial_out), 32'd1);
            chk("abort/hold_done", 32'(tx_done_out), 32'd0);
        end
        @(negedge clk_in);
        nrst_in = 1'b1;
        offer(9'h03C, 7, 1, 1'b1);
        check_frame("after_abort", 1'b0, '0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            idle_check("rand");
            rd = DB'($urandom_range(0, (1 << DB) - 1));
            rl = $urandom_range(0, 15);
            rp = $urandom_range(0, 3);
            rs = 1'($urandom_range(0, 1));
            offer(rd, rl, rp, rs);
            check_frame($sformatf("rand%0d", f), 1'b0, '0, 1'b1);
        end
        idle_check("end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL have parameter OVERSAMPLING, default 16, meaning clock cycles per bit (legal values are 2 and above).
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning the maximum data word width (legal range 5..9).
REQ-003 Port clk_in SHALL be an input, 1 bit: the single clock; all logic uses its rising edge.
REQ-004 Port nrst_in SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port data_valid_in SHALL be an input, 1 bit: the word on tx_data_in is offered for transmission.
REQ-006 Port tx_data_in SHALL be an input, DATA_BITS wide: the data word, sent LSB first.
REQ-007 Port word_len_in SHALL be an input, 4 bits: active data bits per frame (5..DATA_BITS).
REQ-008 Port parity_mode_in SHALL be an input, 2 bits: 00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 Port stop2_in SHALL be an input, 1 bit: 0 selects one stop bit, 1 selects two.
REQ-010 Port tx_ready_out SHALL be an output, 1 bit: the block can accept a word this cycle.
REQ-011 Port tx_serial_out SHALL be an output, 1 bit: the serial line, idle high.
REQ-012 Port tx_busy_out SHALL be an output, 1 bit: a frame is in progress.
REQ-013 Port tx_done_out SHALL be an output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 A word SHALL be accepted on a rising edge where data_valid_in=1 and tx_ready_out=1; tx_data_in, word_len_in, parity_mode_in and stop2_in are captured on that edge.
REQ-015 Changes to any configuration input after acceptance SHALL NOT affect the frame in flight.
REQ-016 The state machine SHALL have states IDLE, START, DATA, PARITY and STOP; unused encodings return to IDLE.
REQ-017 Transitions SHALL be: IDLE to START on acceptance; START to DATA; DATA to PARITY after the last data bit if parity is enabled, otherwise DATA to STOP; PARITY to STOP; STOP to IDLE after one or two stop bits.
REQ-018 Every bit SHALL last exactly OVERSAMPLING cycles.
REQ-019 tx_serial_out SHALL go low on the first cycle after the acceptance edge.
REQ-020 Frame length SHALL be (1 + word_len + parity_en + 1 + stop2) x OVERSAMPLING cycles.
REQ-021 The parity bit SHALL be the XOR of the active data bits for even parity, and its inverse for odd parity.
REQ-022 Data bits at or above word_len SHALL be ignored.
REQ-023 word_len_in values below 5 SHALL be clamped to 5, and values above DATA_BITS clamped to DATA_BITS, at capture.
REQ-024 tx_ready_out SHALL be 1 only in IDLE; tx_busy_out SHALL be the inverse of tx_ready_out.
REQ-025 tx_done_out SHALL pulse high for one cycle, coincident with the STOP-to-IDLE edge.
REQ-026 Back-to-back frames SHALL be supported: acceptance on the first IDLE cycle gives exactly one idle-high cycle between frames.
REQ-027 data_valid_in asserted while busy SHALL be ignored and no data captured; the source holds the word until ready.

Reset
REQ-028 While nrst_in=0, outputs SHALL immediately take tx_serial_out=1, tx_ready_out=1, tx_busy_out=0, tx_done_out=0, with state IDLE and counters at 0, independent of clk_in.
REQ-029 Reset asserted mid-frame SHALL abort the frame with the line high and no tx_done_out pulse.
REQ-030 The first acceptance SHALL be possible on the first rising edge after nrst_in deasserts.

Structure
REQ-031 A shared package uart_pkg SHALL hold the state encoding, the parity-mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and the minimum word length constant (5).
REQ-032 Sub-module uart_baud_cnt SHALL be a $clog2(OVERSAMPLING)-bit counter with a clear input and a bit_end tick output, reusable by a matching receiver.

Verification (OVERSAMPLING=4, DATA_BITS=9 unless noted)
REQ-033 Send 0xA5, word_len 8, no parity, 1 stop -> line carries 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done_out pulses at cycle 40; ready returns.
REQ-034 Send 0xA5 with even parity, then with odd parity -> parity bit 0, then 1; each frame is 44 cycles.
REQ-035 Send 0x1F3, word_len 5, 2 stop -> data bits 1,1,0,0,1 then two high stop bits; frame is 32 cycles; bits 5..8 never appear.
REQ-036 Hold data_valid_in high with 0x55 then 0xAA -> two frames separated by exactly one idle cycle; inputs changed mid-frame are ignored.
REQ-037 Assert nrst_in low at cycle 13 of a frame -> tx_serial_out=1 without waiting for a clock edge; no done pulse; the next frame is correct.
REQ-038 Apply word_len_in=3 and 15 -> behaviour is as if 5 and 9 had been applied.
